// File: rtl/debounce_pkg.sv
// Shared constants and width helper for the debounce bank and its channels.
package debounce_pkg;

    localparam int DEBOUNCE_DELAY_DEFAULT    = 1000;
    localparam int DEBOUNCE_TICK_DIV_DEFAULT = 100;

    // Bits needed to hold values 0..value-1; returns 0 for value <= 1.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        for (int i = 0; i < 32; i++) begin
            if (v > 0) begin
                result = result + 1;
                v      = v >> 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced bit: two-flop synchroniser, candidate/stability counter, clean level and edge pulses.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int   DELAY    = DEBOUNCE_DELAY_DEFAULT,
    parameter logic INIT_BIT = 1'b0
) (
    input  logic clock,
    input  logic reset_n,
    input  logic tick,
    input  logic noisy_bit,
    output logic clean,
    output logic rise,
    output logic fall
);

    localparam int                 CNT_W   = clog2(DELAY + 1);
    localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(DELAY);

    logic             sync0_q;
    logic             sync1_q;
    logic             cand_q,  cand_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             clean_q, clean_d;
    logic             rise_q,  rise_d;
    logic             fall_q,  fall_d;
    logic             hit;

    always_comb begin
        cand_d = cand_q;
        cnt_d  = cnt_q;
        // A new candidate restarts the count even if a tick arrives in the same cycle.
        if (sync1_q != cand_q) begin
            cand_d = sync1_q;
            cnt_d  = '0;
        end else if (tick && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        hit     = (cnt_q == CNT_MAX) && (cand_q != clean_q);
        clean_d = hit ? cand_q : clean_q;
        rise_d  = hit &  cand_q;
        fall_d  = hit & ~cand_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync0_q <= INIT_BIT;
            sync1_q <= INIT_BIT;
            cand_q  <= INIT_BIT;
            cnt_q   <= '0;
            clean_q <= INIT_BIT;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync0_q <= noisy_bit;
            sync1_q <= sync0_q;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign clean = clean_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/debounce_bank.sv
// WIDTH-channel debouncer: one shared tick prescaler feeding independent per-bit filters.
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter int               DELAY    = DEBOUNCE_DELAY_DEFAULT,
    parameter int               TICK_DIV = DEBOUNCE_TICK_DIV_DEFAULT,
    parameter logic [WIDTH-1:0] INIT     = '0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] noisy,
    output logic [WIDTH-1:0] clean,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             any_change,
    output logic             tick
);

    localparam int               PRE_W  = (clog2(TICK_DIV) < 1) ? 1 : clog2(TICK_DIV);
    localparam logic [PRE_W-1:0] P_LAST = PRE_W'(TICK_DIV - 1);

    logic [PRE_W-1:0] p_q, p_d;
    logic             tick_q, tick_d;

    always_comb begin
        if (p_q == P_LAST) begin
            p_d    = '0;
            tick_d = 1'b1;
        end else begin
            p_d    = p_q + PRE_W'(1);
            tick_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            p_q    <= '0;
            tick_q <= 1'b0;
        end else begin
            p_q    <= p_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ch
        debounce_channel #(
            .DELAY    (DELAY),
            .INIT_BIT (INIT[gi])
        ) u_ch (
            .clock     (clock),
            .reset_n   (reset_n),
            .tick      (tick_q),
            .noisy_bit (noisy[gi]),
            .clean     (clean[gi]),
            .rise      (rise[gi]),
            .fall      (fall[gi])
        );
    end

    assign any_change = |(rise | fall);

endmodule

// File: tb/tb_debounce_bank.sv
// Scoreboard bench: stimulus queues expected pulse events, per-DUT monitors pop and compare on any_change.
module tb_debounce_bank;

    typedef struct {
        int         lo;
        int         hi;
        logic [3:0] rise;
        logic [3:0] fall;
        logic [3:0] clean;
    } exp_t;

    logic       clk;
    int         cyc;
    int         n_cmp;
    int         n_bad;
    int         c0;

    logic       rst_a, rst_b, rst_c;
    logic [3:0] noisy_a, noisy_b, noisy_c;
    logic [3:0] clean_a, rise_a, fall_a;
    logic [3:0] clean_b, rise_b, fall_b;
    logic [3:0] clean_c, rise_c, fall_c;
    logic       any_a, any_b, any_c;
    logic       tick_a, tick_b, tick_c;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t q_c[$];

    debounce_bank #(.WIDTH(4), .DELAY(4), .TICK_DIV(1), .INIT(4'h0)) dut_a (
        .clock(clk), .reset_n(rst_a), .noisy(noisy_a), .clean(clean_a),
        .rise(rise_a), .fall(fall_a), .any_change(any_a), .tick(tick_a));

    debounce_bank #(.WIDTH(4), .DELAY(2), .TICK_DIV(4), .INIT(4'h0)) dut_b (
        .clock(clk), .reset_n(rst_b), .noisy(noisy_b), .clean(clean_b),
        .rise(rise_b), .fall(fall_b), .any_change(any_b), .tick(tick_b));

    debounce_bank #(.WIDTH(4), .DELAY(4), .TICK_DIV(1), .INIT(4'hF)) dut_c (
        .clock(clk), .reset_n(rst_c), .noisy(noisy_c), .clean(clean_c),
        .rise(rise_c), .fall(fall_c), .any_change(any_c), .tick(tick_c));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", nm, got, want);
        end else begin
            $display("ok   %s: %0h", nm, got);
        end
    endtask

    task automatic check_evt(input string nm, input exp_t e,
                             input logic [3:0] r, input logic [3:0] f, input logic [3:0] c);
        n_cmp++;
        if (cyc < e.lo || cyc > e.hi || r !== e.rise || f !== e.fall || c !== e.clean) begin
            n_bad++;
            $display("FAIL event_%s: got edge %0d rise %b fall %b clean %b, required edge %0d..%0d rise %b fall %b clean %b",
                     nm, cyc, r, f, c, e.lo, e.hi, e.rise, e.fall, e.clean);
        end else begin
            $display("ok   event_%s: edge %0d rise %b fall %b clean %b", nm, cyc, r, f, c);
        end
    endtask

    task automatic unexpected(input string nm, input logic [3:0] r, input logic [3:0] f, input logic [3:0] c);
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_%s: got rise %b fall %b clean %b at edge %0d, required no event",
                 nm, r, f, c, cyc);
    endtask

    always @(negedge clk) begin : mon_a
        exp_t e;
        if (any_a) begin
            if (q_a.size() == 0) unexpected("a", rise_a, fall_a, clean_a);
            else begin
                e = q_a.pop_front();
                check_evt("a", e, rise_a, fall_a, clean_a);
            end
        end
    end

    always @(negedge clk) begin : mon_b
        exp_t e;
        if (any_b) begin
            if (q_b.size() == 0) unexpected("b", rise_b, fall_b, clean_b);
            else begin
                e = q_b.pop_front();
                check_evt("b", e, rise_b, fall_b, clean_b);
            end
        end
    end

    always @(negedge clk) begin : mon_c
        exp_t e;
        if (any_c) begin
            if (q_c.size() == 0) unexpected("c", rise_c, fall_c, clean_c);
            else begin
                e = q_c.pop_front();
                check_evt("c", e, rise_c, fall_c, clean_c);
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_a(input int edge_n, input logic [3:0] r, input logic [3:0] f, input logic [3:0] c);
        q_a.push_back('{edge_n, edge_n, r, f, c});
    endtask

    initial begin
        logic nb;
        n_cmp   = 0;
        n_bad   = 0;
        rst_a   = 1'b1;
        rst_b   = 1'b1;
        rst_c   = 1'b1;
        noisy_a = 4'hF;
        noisy_b = 4'h0;
        noisy_c = 4'h0;

        // Asynchronous reset assertion before any clock edge
        #1;
        rst_a = 1'b0;
        rst_b = 1'b0;
        rst_c = 1'b0;
        #1;
        chk("reset_clean_a", 32'(clean_a), 32'h0);
        chk("reset_pulses_a", 32'({rise_a, fall_a}), 32'h0);
        chk("reset_any_a", 32'(any_a), 32'h0);
        chk("reset_tick_a", 32'(tick_a), 32'h0);
        chk("reset_clean_b", 32'(clean_b), 32'h0);
        chk("reset_clean_c", 32'(clean_c), 32'hF);

        // Release with all inputs high
        cycles(3);
        rst_a = 1'b1;
        c0 = cyc;
        push_a(c0 + 8, 4'hF, 4'h0, 4'hF);
        cycles(12);

        noisy_a = 4'h0;
        push_a(cyc + 8, 4'h0, 4'hF, 4'h0);
        cycles(12);

        // Three-cycle glitch on bit 1 must be swallowed
        noisy_a = 4'b0010;
        cycles(3);
        noisy_a = 4'b0000;
        cycles(12);
        chk("glitch_clean_a", 32'(clean_a), 32'h0);

        noisy_a = 4'b0010;
        push_a(cyc + 8, 4'b0010, 4'b0000, 4'b0010);
        cycles(12);

        noisy_a = 4'b0100;
        push_a(cyc + 8, 4'b0100, 4'b0010, 4'b0100);
        cycles(12);

        // Simultaneous rise and fall on different channels
        noisy_a = 4'b0001;
        push_a(cyc + 8, 4'b0001, 4'b0100, 4'b0001);
        cycles(12);

        // Reset mid-count, asserted between edges
        noisy_a = 4'b0101;
        cycles(3);
        @(posedge clk);
        #2;
        rst_a = 1'b0;
        #1;
        chk("midreset_clean_a", 32'(clean_a), 32'h0);
        chk("midreset_pulses_a", 32'({rise_a, fall_a, 3'b000, any_a}), 32'h0);
        cycles(3);
        rst_a = 1'b1;
        push_a(cyc + 8, 4'b0101, 4'b0000, 4'b0101);
        cycles(12);

        // Prescaled channel: toggle bit 0 at varying tick phases
        rst_b = 1'b1;
        cycles(4);
        for (int t = 0; t < 100; t++) begin
            nb = ~noisy_b[0];
            noisy_b[0] = nb;
            q_b.push_back('{cyc + 9, cyc + 12, {3'b000, nb}, {3'b000, ~nb}, {3'b000, nb}});
            cycles(13 + int'($urandom_range(0, 3)));
        end

        // INIT all-ones released with inputs low, then a long quiet hold
        rst_c = 1'b1;
        c0 = cyc;
        q_c.push_back('{c0 + 8, c0 + 8, 4'h0, 4'hF, 4'h0});
        cycles(12 + 1000);
        chk("hold_clean_c", 32'(clean_c), 32'h0);

        chk("pending_a", 32'(q_a.size()), 32'h0);
        chk("pending_b", 32'(q_b.size()), 32'h0);
        chk("pending_c", 32'(q_c.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
